// File: rtl/clint_pkg.sv
// Shared register offsets, reset constants and helpers for the core-local interruptor.
// Build option: CLINT_PRESCALER_EN (see clint_timer) selects the mtime prescaler.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI
  } clint_reg_e;

  // Word-aligned decode: the byte offset within the word is dropped before matching.
  function automatic clint_reg_e clintDecode(input logic [15:0] off);
    clint_reg_e sel;
    case ({off[15:2], 2'b00})
      CLINT_MSIP_OFF:        sel = REG_MSIP;
      CLINT_MTIMECMP_LO_OFF: sel = REG_MTIMECMP_LO;
      CLINT_MTIMECMP_HI_OFF: sel = REG_MTIMECMP_HI;
      CLINT_MTIME_LO_OFF:    sel = REG_MTIME_LO;
      CLINT_MTIME_HI_OFF:    sel = REG_MTIME_HI;
      default:               sel = REG_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] applyStrobe(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[b*8 +: 8] = strb[b] ? newVal[b*8 +: 8] : oldVal[b*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime prescaler: emits a one-cycle tick every TICK_DIV cycles, restarted by clear_i.
// Only built when CLINT_PRESCALER_EN is defined.
`ifdef CLINT_PRESCALER_EN
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [15:0] LAST_COUNT = 16'(TICK_DIV - 1);

  logic [15:0] count_q, count_d;

  assign tick_o = (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q + 16'd1;
    if (clear_i || tick_o) count_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule
`endif

// File: rtl/clint_timer.sv
// Machine-mode core-local interruptor: mtime/mtimecmp/msip behind a simple req/ready bus.
// Define CLINT_PRESCALER_EN to divide the mtime increment rate by TICK_DIV.
module clint_timer
  import clint_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [XLEN/8-1:0] wstrb_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              timer_interrupt_o,
  output logic              software_interrupt_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimeCmp_q, mtimeCmp_d;
  logic        msip_q, msip_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        timerIrq_q;

  clint_reg_e sel;
  logic       wrEn, rdEn, anyStrb;
  logic       timeWrLo, timeWrHi, timeWr;
  logic       tick;
  logic       unusedAddr;

  assign sel        = clintDecode(addr_i[15:0]);
  assign unusedAddr = ^{addr_i[XLEN-1:16], addr_i[1:0]};
  assign wrEn       = req_i && write_i;
  assign rdEn       = req_i && !write_i;
  assign anyStrb    = |wstrb_i;
  assign timeWrLo   = wrEn && anyStrb && (sel == REG_MTIME_LO);
  assign timeWrHi   = wrEn && anyStrb && (sel == REG_MTIME_HI);
  assign timeWr     = timeWrLo || timeWrHi;

`ifdef CLINT_PRESCALER_EN
  clint_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(timeWr),
    .tick_o (tick)
  );
`else
  // Without the prescaler every cycle ticks; TICK_DIV is always >= 1 so this is constant 1.
  assign tick = (TICK_DIV != 0);
`endif

  // A software write to mtime takes precedence over the increment for the whole 64 bits.
  always_comb begin
    mtime_d = mtime_q;
    if (timeWr) begin
      if (timeWrLo) mtime_d[31:0]  = applyStrobe(mtime_q[31:0],  wdata_i, wstrb_i);
      if (timeWrHi) mtime_d[63:32] = applyStrobe(mtime_q[63:32], wdata_i, wstrb_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    mtimeCmp_d = mtimeCmp_q;
    if (wrEn && sel == REG_MTIMECMP_LO)
      mtimeCmp_d[31:0] = applyStrobe(mtimeCmp_q[31:0], wdata_i, wstrb_i);
    if (wrEn && sel == REG_MTIMECMP_HI)
      mtimeCmp_d[63:32] = applyStrobe(mtimeCmp_q[63:32], wdata_i, wstrb_i);

    msip_d = msip_q;
    if (wrEn && sel == REG_MSIP && wstrb_i[0]) msip_d = wdata_i[0];

    rdata_d = '0;
    case (sel)
      REG_MSIP:        rdata_d = {31'd0, msip_q};
      REG_MTIMECMP_LO: rdata_d = mtimeCmp_q[31:0];
      REG_MTIMECMP_HI: rdata_d = mtimeCmp_q[63:32];
      REG_MTIME_LO:    rdata_d = mtime_q[31:0];
      REG_MTIME_HI:    rdata_d = mtime_q[63:32];
      default:         rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimeCmp_q <= CLINT_MTIMECMP_RST;
      msip_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      timerIrq_q <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimeCmp_q <= mtimeCmp_d;
      msip_q     <= msip_d;
      rvalid_q   <= rdEn;
      if (rdEn) rdata_q <= rdata_d;
      timerIrq_q <= (mtime_q >= mtimeCmp_q);
    end
  end

  assign ready_o              = 1'b1;
  assign rvalid_o             = rvalid_q;
  assign rdata_o              = rdata_q;
  assign timer_interrupt_o    = timerIrq_q;
  assign software_interrupt_o = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer; build with CLINT_PRESCALER_EN to exercise
// the TICK_DIV=4 prescaler path instead of the per-cycle mtime scenarios.
module tb_clint_timer;

`ifdef CLINT_PRESCALER_EN
  localparam int unsigned TB_DIV = 4;
`else
  localparam int unsigned TB_DIV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, rvalid, timerIrq, swIrq;
  logic [31:0] rdata;

  int nChecks = 0;
  int nFails  = 0;

  clint_timer #(
    .XLEN    (32),
    .TICK_DIV(TB_DIV)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_i               (req),
    .write_i             (write),
    .wstrb_i             (wstrb),
    .addr_i              (addr),
    .wdata_i             (wdata),
    .ready_o             (ready),
    .rvalid_o            (rvalid),
    .rdata_o             (rdata),
    .timer_interrupt_o   (timerIrq),
    .software_interrupt_o(swIrq)
  );

  always #5 clk = ~clk;

  // Each bus operation occupies exactly one rising edge; outputs are sampled 1ns after it.
  task automatic applyStimulus(input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    req = 1'b1; write = wr; addr = a; wdata = d; wstrb = s;
    @(posedge clk);
    #1;
    req = 1'b0; write = 1'b0; wstrb = 4'h0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic v, output logic [31:0] d);
    applyStimulus(1'b0, a, 32'h0, 4'h0);
    v = rvalid;
    d = rdata;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    applyStimulus(1'b1, a, d, s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic v;
    logic [31:0] d, expTime;
    expTime = (TB_DIV == 1) ? 32'd1 : 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
    nChecks++; if (rdata !== 32'h0) begin nFails++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    nChecks++; if (timerIrq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_timer_irq: got %b want 0", timerIrq); end
    nChecks++; if (swIrq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_sw_irq: got %b want 0", swIrq); end
    nChecks++; if (ready !== 1'b1) begin nFails++; $display("[TB] FAIL ready_tied: got %b want 1", ready); end
    @(negedge clk);
    rst = 1'b0;
    busRead(32'h0000_BFF8, v, d);
    nChecks++; if (v !== 1'b1) begin nFails++; $display("[TB] FAIL reset_rd_mtime_valid: got %b want 1", v); end
    nChecks++; if (d !== expTime) begin nFails++; $display("[TB] FAIL reset_rd_mtime: got %h want %h", d, expTime); end
    busRead(32'h0000_4000, v, d);
    nChecks++; if (d !== 32'hFFFF_FFFF) begin nFails++; $display("[TB] FAIL reset_rd_mtimecmp: got %h want ffffffff", d); end
    busRead(32'h0000_0000, v, d);
    nChecks++; if (d !== 32'h0) begin nFails++; $display("[TB] FAIL reset_rd_msip: got %h want 0", d); end
    idle(1);
    nChecks++; if (rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL rvalid_one_cycle: got %b want 0", rvalid); end
    nChecks++; if (timerIrq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_timer_idle: got %b want 0", timerIrq); end
  endtask

  task automatic test_mtime_carry;
    logic v;
    logic [31:0] d;
    busWrite(32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF);
    busWrite(32'h0000_BFFC, 32'h0000_0000, 4'hF);
    idle(2);
    busRead(32'h0000_BFFC, v, d);
    nChecks++; if (d !== 32'h1) begin nFails++; $display("[TB] FAIL carry_hi: got %h want 1", d); end
    busRead(32'h0000_BFF8, v, d);
    nChecks++; if (d !== 32'h1) begin nFails++; $display("[TB] FAIL carry_lo: got %h want 1", d); end
    busWrite(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF);
    busWrite(32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF);
    busRead(32'h0000_BFFC, v, d);
    nChecks++; if (d !== 32'hFFFF_FFFF) begin nFails++; $display("[TB] FAIL allones_hi: got %h want ffffffff", d); end
    nChecks++; if (timerIrq !== 1'b1) begin nFails++; $display("[TB] FAIL equal_compare_irq: got %b want 1", timerIrq); end
    busRead(32'h0000_BFFC, v, d);
    nChecks++; if (d !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_hi: got %h want 0", d); end
    nChecks++; if (timerIrq !== 1'b0) begin nFails++; $display("[TB] FAIL wrap_irq_drop: got %b want 0", timerIrq); end
    busRead(32'h0000_BFF8, v, d);
    nChecks++; if (d !== 32'h1) begin nFails++; $display("[TB] FAIL wrap_lo: got %h want 1", d); end
  endtask

  task automatic test_timer;
    logic v;
    logic [31:0] d;
    busWrite(32'h0000_BFF8, 32'h0, 4'hF);
    busWrite(32'h0000_BFFC, 32'h0, 4'hF);
    busWrite(32'h0000_4004, 32'h0, 4'hF);
    busWrite(32'h0000_4000, 32'd10, 4'hF);
    nChecks++; if (timerIrq !== 1'b0) begin nFails++; $display("[TB] FAIL irq_after_cmp_write: got %b want 0", timerIrq); end
    idle(8);
    nChecks++; if (timerIrq !== 1'b0) begin nFails++; $display("[TB] FAIL irq_at_mtime_10: got %b want 0", timerIrq); end
    idle(1);
    nChecks++; if (timerIrq !== 1'b1) begin nFails++; $display("[TB] FAIL irq_rise: got %b want 1", timerIrq); end
    busWrite(32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
    nChecks++; if (timerIrq !== 1'b1) begin nFails++; $display("[TB] FAIL irq_hold_after_lo: got %b want 1", timerIrq); end
    busWrite(32'h0000_4004, 32'hFFFF_FFFF, 4'hF);
    nChecks++; if (timerIrq !== 1'b0) begin nFails++; $display("[TB] FAIL irq_drop: got %b want 0", timerIrq); end
    busRead(32'h0000_4004, v, d);
    nChecks++; if (d !== 32'hFFFF_FFFF) begin nFails++; $display("[TB] FAIL cmp_hi_readback: got %h want ffffffff", d); end
  endtask

  task automatic test_msip;
    logic v;
    logic [31:0] d;
    busWrite(32'h0000_0000, 32'hFFFF_FFFF, 4'b0001);
    nChecks++; if (swIrq !== 1'b1) begin nFails++; $display("[TB] FAIL msip_set: got %b want 1", swIrq); end
    busRead(32'h0000_0000, v, d);
    nChecks++; if (d !== 32'h1) begin nFails++; $display("[TB] FAIL msip_readback: got %h want 1", d); end
    busWrite(32'h0000_0000, 32'h0, 4'b1110);
    nChecks++; if (swIrq !== 1'b1) begin nFails++; $display("[TB] FAIL msip_upper_strobes: got %b want 1", swIrq); end
    busWrite(32'h0000_0000, 32'h0, 4'b0001);
    nChecks++; if (swIrq !== 1'b0) begin nFails++; $display("[TB] FAIL msip_clear: got %b want 0", swIrq); end
  endtask

  task automatic test_strobes;
    logic v;
    logic [31:0] d;
    busWrite(32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
    busWrite(32'h0000_4000, 32'h1122_3344, 4'b0100);
    busRead(32'h0000_4000, v, d);
    nChecks++; if (d !== 32'hFF22_FFFF) begin nFails++; $display("[TB] FAIL strobe_byte2: got %h want ff22ffff", d); end
    busRead(32'h1234_4003, v, d);
    nChecks++; if (d !== 32'hFF22_FFFF) begin nFails++; $display("[TB] FAIL decode_alias: got %h want ff22ffff", d); end
    busWrite(32'h0000_4000, 32'h0, 4'h0);
    busRead(32'h0000_4000, v, d);
    nChecks++; if (d !== 32'hFF22_FFFF) begin nFails++; $display("[TB] FAIL strobe_zero_noop: got %h want ff22ffff", d); end
    busWrite(32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
    busRead(32'h0000_1000, v, d);
    nChecks++; if (v !== 1'b1) begin nFails++; $display("[TB] FAIL unmapped_rvalid: got %b want 1", v); end
    nChecks++; if (d !== 32'h0) begin nFails++; $display("[TB] FAIL unmapped_rdata: got %h want 0", d); end
    busRead(32'h0000_0000, v, d);
    nChecks++; if (d !== 32'h0) begin nFails++; $display("[TB] FAIL unmapped_no_side_effect: got %h want 0", d); end
  endtask

  task automatic test_back_to_back;
    logic v;
    logic [31:0] d;
    busWrite(32'h0000_4004, 32'h1234_5678, 4'hF);
    nChecks++; if (rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL write_no_rvalid: got %b want 0", rvalid); end
    busRead(32'h0000_4004, v, d);
    nChecks++; if (v !== 1'b1 || d !== 32'h1234_5678) begin nFails++; $display("[TB] FAIL b2b_rd0: got %b/%h want 1/12345678", v, d); end
    busRead(32'h0000_4000, v, d);
    nChecks++; if (v !== 1'b1 || d !== 32'hFF22_FFFF) begin nFails++; $display("[TB] FAIL b2b_rd1: got %b/%h want 1/ff22ffff", v, d); end
    busRead(32'h0000_0000, v, d);
    nChecks++; if (v !== 1'b1 || d !== 32'h0) begin nFails++; $display("[TB] FAIL b2b_rd2: got %b/%h want 1/0", v, d); end
    idle(1);
    nChecks++; if (rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_rvalid_end: got %b want 0", rvalid); end
  endtask

  task automatic test_reset_mid;
    logic v;
    logic [31:0] d;
    @(negedge clk);
    req = 1'b1; write = 1'b0; addr = 32'h0000_4004;
    @(posedge clk);
    #1;
    nChecks++; if (rvalid !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_accept: got %b want 1", rvalid); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    nChecks++; if (rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_rvalid_drop: got %b want 0", rvalid); end
    nChecks++; if (rdata !== 32'h0) begin nFails++; $display("[TB] FAIL midrst_rdata: got %h want 0", rdata); end
    @(negedge clk);
    rst = 1'b0; addr = 32'h0000_BFF8;
    @(posedge clk);
    #1;
    req = 1'b0;
    nChecks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin nFails++; $display("[TB] FAIL midrst_mtime: got %b/%h want 1/0", rvalid, rdata); end
    busRead(32'h0000_4004, v, d);
    nChecks++; if (d !== 32'hFFFF_FFFF) begin nFails++; $display("[TB] FAIL midrst_cmp: got %h want ffffffff", d); end
  endtask

`ifdef CLINT_PRESCALER_EN
  task automatic test_prescaler;
    logic v;
    logic [31:0] d, expLo;
    idle(2);
    busWrite(32'h0000_BFF8, 32'd5, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      expLo = 32'd5 + 32'((k - 1) / 4);
      busRead(32'h0000_BFF8, v, d);
      nChecks++; if (d !== expLo) begin nFails++; $display("[TB] FAIL prescale_read%0d: got %h want %h", k, d, expLo); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef CLINT_PRESCALER_EN
    test_mtime_carry();
    test_timer();
`endif
    test_msip();
    test_strobes();
    test_back_to_back();
    test_reset_mid();
`ifdef CLINT_PRESCALER_EN
    test_prescaler();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
